// File: rtl/ofdm_rx_sample_pacer_pkg.sv
// Shared types, widths and helpers for the OFDM RX sample pacer.
package ofdm_pacer_pkg;

  localparam int BIT_CNT_W = 16;
  localparam int PERIOD_W  = 16;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_SAT = '1;

  typedef enum logic [1:0] {
    PACER_IDLE    = 2'd0,
    PACER_RUN     = 2'd1,
    PACER_DONE    = 2'd2,
    PACER_TIMEOUT = 2'd3
  } pacer_state_t;

  function automatic logic [BIT_CNT_W-1:0] sat_add(input logic [BIT_CNT_W-1:0] a,
                                                   input logic [BIT_CNT_W-1:0] b);
    logic [BIT_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[BIT_CNT_W] ? BIT_CNT_SAT : sum[BIT_CNT_W-1:0];
  endfunction

  // Periods of 0 and 1 both mean one sample per cycle.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_W'(2)) ? PERIOD_W'(1) : p;
  endfunction

endpackage

// File: rtl/ofdm_rx_sample_pacer_if.sv
// Producer-side sample handshake of the OFDM RX sample pacer.
interface ofdm_rx_sample_pacer_if #(parameter int sample_bit_width_g = 12);

  logic [sample_bit_width_g-1:0] in_i;
  logic [sample_bit_width_g-1:0] in_q;
  logic                          in_valid;
  logic                          in_ready;

  modport master (output in_i, in_q, in_valid, input in_ready);
  modport slave  (input in_i, in_q, in_valid, output in_ready);

endinterface

// File: rtl/ofdm_rx_sample_pacer_fifo.sv
// Single-clock sample FIFO (I/Q concatenated) with occupancy and synchronous clear.
module ofdm_sample_fifo #(
  parameter int data_w_g  = 24,
  parameter int depth_g   = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rstn,
  input  logic                      clear,
  input  logic                      push,
  input  logic [data_w_g-1:0]       push_data,
  input  logic                      pop,
  output logic [data_w_g-1:0]       pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(depth_g):0]  level
);

  localparam int AW = $clog2(depth_g);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(depth_g);

  logic [data_w_g-1:0] mem [depth_g];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ofdm_rx_sample_pacer.sv
// Replays buffered I/Q samples at a programmable strobe period and counts RX output bits.
// Optional watchdog and TIMEOUT state are built when OFDM_PACER_TIMEOUT_EN is defined.
module ofdm_rx_sample_pacer
  import ofdm_pacer_pkg::*;
#(
  parameter int sample_bit_width_g = 12,
  parameter int fifo_depth_g       = 16,
  parameter int bits_per_valid_g   = 2,
  parameter int timeout_cycles_g   = 500000
) (
  input  logic                              sys_clk,
  input  logic                              sys_rstn,
  input  logic                              sys_init,
  input  logic [PERIOD_W-1:0]               strobe_period_i,
  input  logic [BIT_CNT_W-1:0]              target_bits_i,
  ofdm_rx_sample_pacer_if.slave             src,
  output logic [sample_bit_width_g-1:0]     rx_data_i,
  output logic [sample_bit_width_g-1:0]     rx_data_q,
  output logic                              rx_data_valid,
  input  logic                              rcv_data_valid,
  output logic [BIT_CNT_W-1:0]              bits_cnt_o,
  output logic [$clog2(fifo_depth_g):0]     fifo_level_o,
  output logic                              underrun_o,
  output logic                              done_o,
  output logic                              timeout_o
);

  localparam logic [1:0] ST_IDLE    = PACER_IDLE;
  localparam logic [1:0] ST_RUN     = PACER_RUN;
  localparam logic [1:0] ST_DONE    = PACER_DONE;
  localparam logic [1:0] ST_TIMEOUT = PACER_TIMEOUT;
  localparam int DATA_W = 2 * sample_bit_width_g;

  logic [1:0]           state;
  logic [PERIOD_W-1:0]  period_q;
  logic [PERIOD_W-1:0]  strobe_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_W-1:0]    fifo_dout;
  logic                 strobe;
  logic                 pop;
  logic [BIT_CNT_W-1:0] bits_next;
  logic                 run_done;
  logic                 run_timeout;

  assign src.in_ready = !fifo_full;
  assign strobe       = (state == ST_RUN) && (strobe_cnt == period_q - 1'b1);
  assign pop          = strobe && !fifo_empty;
  assign bits_next    = rcv_data_valid ? sat_add(bits_cnt_o, BIT_CNT_W'(bits_per_valid_g))
                                       : bits_cnt_o;
  assign run_done     = (bits_next >= target_bits_i);
  assign done_o       = (state == ST_DONE);

  ofdm_sample_fifo #(
    .data_w_g (DATA_W),
    .depth_g  (fifo_depth_g)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .clear     (sys_init),
    .push      (src.in_valid),
    .push_data ({src.in_i, src.in_q}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

`ifdef OFDM_PACER_TIMEOUT_EN
  localparam int WD_W = $clog2(timeout_cycles_g + 1);
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside RUN so every run starts with a fresh budget.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn)                         wd_cnt <= '0;
    else if (sys_init || state != ST_RUN)  wd_cnt <= '0;
    else                                   wd_cnt <= wd_cnt + 1'b1;
  end

  assign run_timeout = (wd_cnt == WD_W'(timeout_cycles_g - 1));
  assign timeout_o   = (state == ST_TIMEOUT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (timeout_cycles_g != 0);
  assign run_timeout        = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  // DONE takes precedence over TIMEOUT when both trigger on the same edge.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state         <= ST_IDLE;
      period_q      <= PERIOD_W'(1);
      strobe_cnt    <= '0;
      bits_cnt_o    <= '0;
      underrun_o    <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_data_i     <= '0;
      rx_data_q     <= '0;
    end else if (sys_init) begin
      state         <= ST_IDLE;
      strobe_cnt    <= '0;
      bits_cnt_o    <= '0;
      underrun_o    <= 1'b0;
      rx_data_valid <= 1'b0;
    end else begin
      rx_data_valid <= pop;
      if (pop) {rx_data_i, rx_data_q} <= fifo_dout;
      if (strobe && fifo_empty) underrun_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state      <= ST_RUN;
            strobe_cnt <= '0;
            period_q   <= eff_period(strobe_period_i);
          end
        end
        ST_RUN: begin
          strobe_cnt <= strobe ? '0 : strobe_cnt + 1'b1;
          bits_cnt_o <= bits_next;
          if (run_done)         state <= ST_DONE;
          else if (run_timeout) state <= ST_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_rx_sample_pacer.sv
// Self-checking bench for ofdm_rx_sample_pacer: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours OFDM_PACER_TIMEOUT_EN like the RTL.
module tb_ofdm_rx_sample_pacer;

  localparam int W      = 12;
  localparam int DEPTH  = 16;
  localparam int BPV    = 2;
  localparam int TO_CYC = 300;
`ifdef OFDM_PACER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TOUT = 3;

  logic          sys_clk        = 1'b0;
  logic          sys_rstn       = 1'b0;
  logic          sys_init       = 1'b0;
  logic [15:0]   strobe_period  = 16'd1;
  logic [15:0]   target_bits    = 16'hFFFF;
  logic          rcv_data_valid = 1'b0;
  logic [W-1:0]  rx_data_i;
  logic [W-1:0]  rx_data_q;
  logic          rx_data_valid;
  logic [15:0]   bits_cnt;
  logic [$clog2(DEPTH):0] fifo_level;
  logic          underrun;
  logic          done;
  logic          timeout;

  ofdm_rx_sample_pacer_if #(.sample_bit_width_g(W)) src ();

  ofdm_rx_sample_pacer #(
    .sample_bit_width_g (W),
    .fifo_depth_g       (DEPTH),
    .bits_per_valid_g   (BPV),
    .timeout_cycles_g   (TO_CYC)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rstn        (sys_rstn),
    .sys_init        (sys_init),
    .strobe_period_i (strobe_period),
    .target_bits_i   (target_bits),
    .src             (src),
    .rx_data_i       (rx_data_i),
    .rx_data_q       (rx_data_q),
    .rx_data_valid   (rx_data_valid),
    .rcv_data_valid  (rcv_data_valid),
    .bits_cnt_o      (bits_cnt),
    .fifo_level_o    (fifo_level),
    .underrun_o      (underrun),
    .done_o          (done),
    .timeout_o       (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int pulse_cyc[$];
  int pulse_dat[$];

  // Reference model state: queued samples, run phase and sticky flags.
  logic [2*W-1:0] m_fifo[$];
  int             m_mode = M_IDLE;
  int             m_k    = 0;
  int             m_p    = 1;
  int             m_bits = 0;
  bit             m_under = 1'b0;
  bit             m_rxv   = 1'b0;
  logic [2*W-1:0] m_rxd   = '0;
  bit             m_can_push;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic applyStimulus(input bit valid, input int data, input bit rcv, input bit init);
    src.in_valid   = valid;
    src.in_i       = W'(data);
    src.in_q       = W'(data >>> W);
    rcv_data_valid = rcv;
    sys_init       = init;
    stepCycle();
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial forever begin
    @(negedge sys_clk);
    if (rx_data_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(int'(rx_data_i));
    end
  end

  // Model: strobes fall on run cycles k where k mod P == P-1, counted from the first RUN edge.
  initial forever begin
    @(posedge sys_clk or negedge sys_rstn);
    if (!sys_rstn || sys_init) begin
      m_fifo.delete();
      m_mode  = M_IDLE;
      m_bits  = 0;
      m_under = 1'b0;
      m_rxv   = 1'b0;
      if (!sys_rstn) m_rxd = '0;
    end else begin
      m_can_push = src.in_valid && (m_fifo.size() < DEPTH);
      m_rxv = 1'b0;
      if (m_mode == M_IDLE) begin
        if (m_fifo.size() > 0) begin
          m_mode = M_RUN;
          m_k    = 0;
          m_p    = (strobe_period < 16'd2) ? 1 : int'(strobe_period);
        end
      end else if (m_mode == M_RUN) begin
        if (m_k % m_p == m_p - 1) begin
          if (m_fifo.size() > 0) begin
            m_rxd = m_fifo.pop_front();
            m_rxv = 1'b1;
          end else begin
            m_under = 1'b1;
          end
        end
        if (rcv_data_valid) m_bits = (m_bits + BPV > 65535) ? 65535 : m_bits + BPV;
        if (m_bits >= int'(target_bits))          m_mode = M_DONE;
        else if (TO_EN && (m_k + 1 == TO_CYC))    m_mode = M_TOUT;
        m_k++;
      end
      if (m_can_push) m_fifo.push_back({src.in_i, src.in_q});
    end
  end

  initial forever begin
    @(negedge sys_clk);
    checkOutput("rx_valid", int'(rx_data_valid), int'(m_rxv));
    if (m_rxv && rx_data_valid) checkOutput("rx_data", int'({rx_data_i, rx_data_q}), int'(m_rxd));
    checkOutput("in_ready", int'(src.in_ready), int'(m_fifo.size() < DEPTH));
    checkOutput("level", int'(fifo_level), m_fifo.size());
    checkOutput("bits", int'(bits_cnt), m_bits);
    checkOutput("underrun", int'(underrun), int'(m_under));
    checkOutput("done", int'(done), int'(m_mode == M_DONE));
    checkOutput("timeout", int'(timeout), int'(m_mode == M_TOUT));
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: got still running, expected finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int t0;
    int base;
    int acc;
    int first_to;
    bit took;
    bit full_seen;

    src.in_valid = 1'b0;
    src.in_i     = '0;
    src.in_q     = '0;
    repeat (3) stepCycle();
    checkOutput("reset_rx_valid", int'(rx_data_valid), 0);
    checkOutput("reset_in_ready", int'(src.in_ready), 1);
    checkOutput("reset_level", int'(fifo_level), 0);
    checkOutput("reset_flags", int'({underrun, done, timeout}), 0);
    sys_rstn = 1'b1;
    stepCycle();

    // Four samples at P=25, then an underrun at the fifth strobe.
    $display("[TB] period 25 replay");
    strobe_period = 16'd25;
    base = pulse_cyc.size();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, k, 1'b0, 1'b0);
      if (k == 1) t0 = cyc;
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    while (cyc < t0 + 125) stepCycle();
    checkOutput("A_pulse_count", pulse_cyc.size() - base, 4);
    for (int k = 0; k < 4 && base + k < pulse_cyc.size(); k++) begin
      checkOutput("A_pulse_time", pulse_cyc[base+k] - t0, 26 + 25 * k);
      checkOutput("A_pulse_data", pulse_dat[base+k], k + 1);
    end
    checkOutput("A_underrun_before", int'(underrun), 0);
    stepCycle();
    checkOutput("A_underrun_fifth", int'(underrun), 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);

    // Fill to full with a long period; the 17th sample waits for the first pop.
    $display("[TB] fifo fill");
    strobe_period = 16'd100;
    base = pulse_cyc.size();
    acc = 0;
    full_seen = 1'b0;
    for (int c = 0; c < 300 && acc < 17; c++) begin
      src.in_valid = 1'b1;
      src.in_i     = W'(acc + 1);
      src.in_q     = '0;
      @(negedge sys_clk);
      if (acc == 16 && !full_seen) begin
        full_seen = 1'b1;
        checkOutput("B_level_full", int'(fifo_level), 16);
        checkOutput("B_ready_low", int'(src.in_ready), 0);
      end
      took = src.in_ready;
      stepCycle();
      if (took) acc++;
    end
    src.in_valid = 1'b0;
    checkOutput("B_accepted", acc, 17);
    checkOutput("B_level_after", int'(fifo_level), 16);
    checkOutput("B_pulses", pulse_cyc.size() - base, 1);
    if (pulse_cyc.size() > base) checkOutput("B_first_data", pulse_dat[base], 1);

    // Soft clear mid-run with samples queued.
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("E_level", int'(fifo_level), 0);
    checkOutput("E_bits", int'(bits_cnt), 0);
    checkOutput("E_rx_valid", int'(rx_data_valid), 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("E_idle_no_pulse", int'(rx_data_valid), 0);

    // Bit target of 8 reached by four receive strobes; pops stop in DONE.
    $display("[TB] bit target");
    strobe_period = 16'd3;
    target_bits   = 16'd8;
    base = pulse_cyc.size();
    for (int k = 1; k <= 10; k++) applyStimulus(1'b1, 40 + k, 1'b0, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      checkOutput("C_bits", int'(bits_cnt), 2 * j);
      checkOutput("C_done", int'(done), (j == 4) ? 1 : 0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
    end
    repeat (20) stepCycle();
    checkOutput("C_pulses", pulse_cyc.size() - base, 5);
    checkOutput("C_level_frozen", int'(fifo_level), 5);
    checkOutput("C_done_held", int'(done), 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);

    // Watchdog: fires TO_CYC cycles into RUN only when built.
    $display("[TB] watchdog");
    strobe_period = 16'd5;
    target_bits   = 16'hFFFF;
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    t0 = cyc;
    applyStimulus(1'b1, 8, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    first_to = -1;
    for (int c = 0; c < TO_CYC + 10; c++) begin
      stepCycle();
      if (timeout && first_to < 0) first_to = cyc - t0;
    end
    checkOutput("D_timeout_cycle", first_to, TO_EN ? TO_CYC + 1 : -1);
    checkOutput("D_timeout_level", int'(timeout), int'(TO_EN));
    applyStimulus(1'b0, 0, 1'b0, 1'b1);

    // Periods 0 and 1 both give back-to-back pulses.
    for (int p = 0; p <= 1; p++) begin
      strobe_period = 16'(p);
      base = pulse_cyc.size();
      for (int k = 1; k <= 4; k++) begin
        applyStimulus(1'b1, 60 + k, 1'b0, 1'b0);
        if (k == 1) t0 = cyc;
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      repeat (6) stepCycle();
      checkOutput("F_pulse_count", pulse_cyc.size() - base, 4);
      for (int k = 0; k < 4 && base + k < pulse_cyc.size(); k++)
        checkOutput("F_pulse_time", pulse_cyc[base+k] - t0, 2 + k);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
    end

    // Asynchronous reset between edges.
    $display("[TB] async reset");
    strobe_period = 16'd2;
    for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 80 + k, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    repeat (8) stepCycle();
    sys_rstn = 1'b0;
    #1;
    checkOutput("G_rx_valid", int'(rx_data_valid), 0);
    checkOutput("G_rx_data", int'({rx_data_i, rx_data_q}), 0);
    checkOutput("G_in_ready", int'(src.in_ready), 1);
    checkOutput("G_bits", int'(bits_cnt), 0);
    checkOutput("G_level", int'(fifo_level), 0);
    checkOutput("G_flags", int'({underrun, done, timeout}), 0);
    stepCycle();
    stepCycle();
    sys_rstn = 1'b1;
    stepCycle();

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    target_bits = 16'd20;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        target_bits = 16'($urandom_range(2, 60));
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
      end else begin
        if ($urandom_range(0, 15) == 0) strobe_period = 16'($urandom_range(0, 7));
        applyStimulus($urandom_range(0, 2) != 0, int'($urandom), $urandom_range(0, 4) == 0, 1'b0);
      end
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    @(negedge sys_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
